// File: rtl/manchester_encoder_if.sv
// Bit handshake between the frame encoder (master) and the Manchester encoder (slave).
interface manchester_encoder_if;
    logic in_valid;
    logic in_data;
    logic in_last;
    logic in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/manchester_encoder.sv
// PICC->PCD Manchester bit encoder: frames a bit stream as SOF + data + EOF and
// drives the subcarrier enable (high = loaded half-bit). All outputs are registered
// and are computed from the next state/count so that they line up with state/cnt.
module manchester_encoder #(
    parameter int unsigned BIT_PERIOD = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    manchester_encoder_if.slave  bus,
    output logic                 en_subcarrier,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    localparam int unsigned CntW = $clog2(BIT_PERIOD);
    localparam logic [CntW-1:0] LastCnt = CntW'(BIT_PERIOD - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(BIT_PERIOD / 2);

    typedef enum logic [1:0] {
        StIdle,
        StSof,
        StData,
        StEof
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            data_q, data_d;
    logic            last_q, last_d;
    // Frame ended through an underrun: suppresses done at the end of its EOF.
    logic            abort_q, abort_d;
    logic            en_q, en_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            underrun_q, underrun_d;

    logic accept;
    logic end_bit;
    logic first_half;

    assign accept  = bus.in_valid && ready_q;
    assign end_bit = (cnt_q == LastCnt);

    // Next-state, bit counter and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        last_d     = last_q;
        abort_d    = abort_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.in_valid) begin
                    state_d = StSof;
                    abort_d = 1'b0;
                end
            end
            StSof: begin
                if (end_bit) begin
                    cnt_d = '0;
                    if (accept) begin
                        state_d = StData;
                        data_d  = bus.in_data;
                        last_d  = bus.in_last;
                    end else begin
                        state_d    = StEof;
                        underrun_d = 1'b1;
                        abort_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (end_bit) begin
                    cnt_d = '0;
                    if (last_q) begin
                        state_d = StEof;
                    end else if (accept) begin
                        data_d = bus.in_data;
                        last_d = bus.in_last;
                    end else begin
                        state_d    = StEof;
                        underrun_d = 1'b1;
                        abort_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StEof: begin
                if (end_bit) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    done_d  = !abort_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        first_half = (cnt_d < HalfCnt);

        unique case (state_d)
            StSof:   en_d = first_half;
            StData:  en_d = first_half ? data_d : ~data_d;
            default: en_d = 1'b0;
        endcase

        busy_d  = (state_d != StIdle);
        // Offered once per bit period, never on a latched final bit.
        ready_d = (cnt_d == LastCnt) &&
                  ((state_d == StSof) || ((state_d == StData) && !last_d));
    end

    // State and registered outputs; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_q     <= 1'b0;
            last_q     <= 1'b0;
            abort_q    <= 1'b0;
            en_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            last_q     <= last_d;
            abort_q    <= abort_d;
            en_q       <= en_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign en_subcarrier = en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign underrun      = underrun_q;

endmodule
